dmem_req: RTL and testbench

- Data-memory request stage, directly upstream of the mem stage.
- Takes the execute-stage memory op, address and store data, and drives the data-SRAM-like request/response interface. Produces byte strobes, aligned store data and the access size.
- Returns the raw 32-bit read word and the low address bits, which mem aligns and extends.
- Owns the request FSM, buffers a response that arrives while the pipeline is stalled, and raises stallreq while an access is outstanding.

---
 rtl/dmem_req_pkg.sv | 32 +++
 rtl/dmem_store_align.sv | 56 +++++
 rtl/dmem_req.sv | 185 ++++++++++++++++++
 tb/tb_dmem_req.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_pkg.sv
// Shared definitions for the data-memory request stage: memop bit positions,
// access size encodings and the request FSM state encoding.
package dmem_req_pkg;

  localparam int DMEM_MMOP_W = 12;

  localparam int MOP_LB  = 0;
  localparam int MOP_LBU = 1;
  localparam int MOP_LH  = 2;
  localparam int MOP_LHU = 3;
  localparam int MOP_LW  = 4;
  localparam int MOP_SB  = 5;
  localparam int MOP_SH  = 6;
  localparam int MOP_SW  = 7;
  localparam int MOP_LWL = 8;
  localparam int MOP_LWR = 9;
  localparam int MOP_SWL = 10;
  localparam int MOP_SWR = 11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DISCARD = 3'd4
  } dmem_state_e;

endpackage

// File: rtl/dmem_store_align.sv
// Combinational translation of memop + low address bits + store data into
// bus access size, byte strobes and lane-aligned write data.
module dmem_store_align
  import dmem_req_pkg::*;
(
  input  logic [DMEM_MMOP_W-1:0] memop,
  input  logic [1:0]             addr_low,
  input  logic [31:0]            rt,
  output logic                   wr,
  output logic [1:0]             size,
  output logic                   word_align,
  output logic [3:0]             wstrb,
  output logic [31:0]            wdata
);

  logic [3:0] byte_strb;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_strb
      assign byte_strb[gi] = (addr_low == 2'(gi));
    end
  endgenerate

  always_comb begin
    wr         = memop[MOP_SB] | memop[MOP_SH] | memop[MOP_SW] |
                 memop[MOP_SWL] | memop[MOP_SWR];
    word_align = memop[MOP_LWL] | memop[MOP_LWR] | memop[MOP_SWL] | memop[MOP_SWR];
    size       = SIZE_WORD;
    wstrb      = 4'b0000;
    wdata      = 32'h0;
    if (memop[MOP_LB] | memop[MOP_LBU] | memop[MOP_SB]) begin
      size = SIZE_BYTE;
    end else if (memop[MOP_LH] | memop[MOP_LHU] | memop[MOP_SH]) begin
      size = SIZE_HALF;
    end
    // Unaligned-word stores: swl fills the low lanes, swr the high lanes
    if (memop[MOP_SB]) begin
      wstrb = byte_strb;
      wdata = {4{rt[7:0]}};
    end else if (memop[MOP_SH]) begin
      wstrb = addr_low[1] ? 4'b1100 : 4'b0011;
      wdata = {2{rt[15:0]}};
    end else if (memop[MOP_SW]) begin
      wstrb = 4'b1111;
      wdata = rt;
    end else if (memop[MOP_SWL]) begin
      wstrb = 4'b1111 >> ~addr_low;
      wdata = rt >> {~addr_low, 3'b000};
    end else if (memop[MOP_SWR]) begin
      wstrb = 4'b1111 << addr_low;
      wdata = rt << {addr_low, 3'b000};
    end
  end

endmodule

// File: rtl/dmem_req.sv
// Data-memory request stage: drives the SRAM-like request bus, buffers a
// response caught during a stall. DMEM_EXC_EN enables misalignment exceptions.
module dmem_req
  import dmem_req_pkg::*;
#(
  parameter int MMOP_W = DMEM_MMOP_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [MMOP_W-1:0] ex_memop_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [31:0]       ex_storedata_i,
  input  logic              pipe_stall_i,
  input  logic              pipe_flush_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [31:0]       data_rdata_i,
  output logic [31:0]       mem_memdata_o,
  output logic [1:0]        mem_memaddr_low_o,
  output logic              dmem_stallreq_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  dmem_state_e state_reg, state_next;

  logic              al_wr, al_word_align;
  logic [1:0]        al_size;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic [ADDR_W-1:0] al_addr;

  logic              wr_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        wstrb_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       buf_reg;
  logic              buf_valid_reg;
  logic [1:0]        addr_low_reg;
  logic              addr_err, start, in_addr;

  dmem_store_align u_align (
    .memop      (ex_memop_i),
    .addr_low   (ex_addr_i[1:0]),
    .rt         (ex_storedata_i),
    .wr         (al_wr),
    .size       (al_size),
    .word_align (al_word_align),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata)
  );

  assign al_addr = al_word_align ? {ex_addr_i[ADDR_W-1:2], 2'b00} : ex_addr_i;

`ifdef DMEM_EXC_EN
  logic              misaligned, adel_reg, ades_reg;
  logic [ADDR_W-1:0] badvaddr_reg;

  assign misaligned = ((ex_memop_i[MOP_LH] | ex_memop_i[MOP_LHU] | ex_memop_i[MOP_SH]) & ex_addr_i[0]) |
                      ((ex_memop_i[MOP_LW] | ex_memop_i[MOP_SW]) & (ex_addr_i[1:0] != 2'b00));
  assign addr_err   = ex_valid_i & misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      adel_reg     <= 1'b0;
      ades_reg     <= 1'b0;
      badvaddr_reg <= '0;
    end else if (!pipe_stall_i) begin
      adel_reg     <= addr_err & ~al_wr & ~pipe_flush_i;
      ades_reg     <= addr_err & al_wr & ~pipe_flush_i;
      badvaddr_reg <= (addr_err & ~pipe_flush_i) ? ex_addr_i : '0;
    end
  end

  assign adel_o     = adel_reg;
  assign ades_o     = ades_reg;
  assign badvaddr_o = badvaddr_reg;
`else
  assign addr_err   = 1'b0;
  assign adel_o     = 1'b0;
  assign ades_o     = 1'b0;
  assign badvaddr_o = '0;
`endif

  assign start   = ~rst & ex_valid_i & (|ex_memop_i) & ~pipe_flush_i & ~addr_err;
  assign in_addr = (state_reg == ST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = data_addr_ok_i ? ST_DATA : ST_ADDR;
      // An accepted address always yields a response, so it must be drained
      ST_ADDR: begin
        if (pipe_flush_i)        state_next = data_addr_ok_i ? ST_DISCARD : ST_IDLE;
        else if (data_addr_ok_i) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (data_data_ok_i)    state_next = (pipe_flush_i || !pipe_stall_i) ? ST_IDLE : ST_HOLD;
        else if (pipe_flush_i) state_next = ST_DISCARD;
      end
      ST_HOLD:    if (pipe_flush_i || !pipe_stall_i) state_next = ST_IDLE;
      ST_DISCARD: if (data_data_ok_i) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    data_req_o      = 1'b0;
    dmem_stallreq_o = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        data_req_o      = start;
        dmem_stallreq_o = start;
      end
      ST_ADDR: begin
        data_req_o      = 1'b1;
        dmem_stallreq_o = 1'b1;
      end
      ST_DATA:    dmem_stallreq_o = ~data_data_ok_i;
      ST_DISCARD: dmem_stallreq_o = 1'b1;
      default:    ;
    endcase
  end

  assign data_wr_o    = in_addr ? wr_reg    : al_wr;
  assign data_size_o  = in_addr ? size_reg  : al_size;
  assign data_addr_o  = in_addr ? addr_reg  : al_addr;
  assign data_wstrb_o = in_addr ? wstrb_reg : al_wstrb;
  assign data_wdata_o = in_addr ? wdata_reg : al_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      size_reg  <= SIZE_BYTE;
      addr_reg  <= '0;
      wstrb_reg <= 4'b0000;
      wdata_reg <= 32'h0;
    end else if (state_reg == ST_IDLE && start) begin
      wr_reg    <= al_wr;
      size_reg  <= al_size;
      addr_reg  <= al_addr;
      wstrb_reg <= al_wstrb;
      wdata_reg <= al_wdata;
    end
  end

  // Buffer stays valid for the cycle after the stage advances so mem can take it
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg       <= 32'h0;
      buf_valid_reg <= 1'b0;
    end else if (state_reg == ST_DATA && data_data_ok_i && !pipe_flush_i) begin
      buf_reg       <= data_rdata_i;
      buf_valid_reg <= 1'b1;
    end else if (pipe_flush_i || (state_reg != ST_HOLD && !pipe_stall_i)) begin
      buf_reg       <= 32'h0;
      buf_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               addr_low_reg <= 2'b00;
    else if (!pipe_stall_i) addr_low_reg <= ex_addr_i[1:0];
  end

  assign mem_memaddr_low_o = addr_low_reg;
  assign mem_memdata_o     = buf_valid_reg ? buf_reg :
                             ((state_reg == ST_DATA && data_data_ok_i && !pipe_flush_i) ? data_rdata_i : 32'h0);

endmodule

// File: tb/tb_dmem_req.sv
// Scoreboard bench for dmem_req: expected bus requests and read words are
// queued when stimulus is driven and popped when the DUT presents them.
module tb_dmem_req;

  localparam int MMOP_W = 12;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid_i;
  logic [MMOP_W-1:0] ex_memop_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [31:0]       ex_storedata_i;
  logic              pipe_stall_i, pipe_flush_i;
  logic              data_req_o, data_wr_o;
  logic [1:0]        data_size_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [3:0]        data_wstrb_o;
  logic [31:0]       data_wdata_o;
  logic              data_addr_ok_i, data_data_ok_i;
  logic [31:0]       data_rdata_i;
  logic [31:0]       mem_memdata_o;
  logic [1:0]        mem_memaddr_low_o;
  logic              dmem_stallreq_o, adel_o, ades_o;
  logic [ADDR_W-1:0] badvaddr_o;

  dmem_req #(.MMOP_W(MMOP_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_memop_i(ex_memop_i), .ex_addr_i(ex_addr_i),
    .ex_storedata_i(ex_storedata_i), .pipe_stall_i(pipe_stall_i), .pipe_flush_i(pipe_flush_i),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
    .mem_memdata_o(mem_memdata_o), .mem_memaddr_low_o(mem_memaddr_low_o),
    .dmem_stallreq_o(dmem_stallreq_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  req_t        req_q[$];
  logic [31:0] rd_q[$];
  req_t        got, exp;
  logic [31:0] exp_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ex(input int op, input logic [31:0] addr, input logic [31:0] rt);
    logic [MMOP_W-1:0] one;
    one            = 12'd1;
    ex_valid_i     = 1'b1;
    ex_memop_i     = one << op;
    ex_addr_i      = addr;
    ex_storedata_i = rt;
  endtask

  task automatic clear_ex();
    ex_valid_i     = 1'b0;
    ex_memop_i     = '0;
    ex_addr_i      = '0;
    ex_storedata_i = '0;
  endtask

  function automatic req_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [31:0] wdata);
    req_t r;
    r.wr = wr; r.size = size; r.addr = addr; r.wstrb = wstrb; r.wdata = wdata;
    return r;
  endfunction

  // Reference request for an op index; load write data is don't-care, so it is compared as 0
  function automatic req_t model(input int op, input logic [31:0] addr, input logic [31:0] rt);
    req_t r;
    r = mk(1'b0, 2'd2, addr, 4'b0000, 32'h0);
    case (op)
      0, 1: r.size = 2'd0;
      2, 3: r.size = 2'd1;
      5: begin
        r.wr = 1'b1; r.size = 2'd0; r.wdata = {4{rt[7:0]}};
        case (addr[1:0])
          2'd0: r.wstrb = 4'b0001;
          2'd1: r.wstrb = 4'b0010;
          2'd2: r.wstrb = 4'b0100;
          default: r.wstrb = 4'b1000;
        endcase
      end
      6: begin
        r.wr = 1'b1; r.size = 2'd1; r.wdata = {2{rt[15:0]}};
        r.wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      7: begin r.wr = 1'b1; r.wstrb = 4'b1111; r.wdata = rt; end
      8, 9: r.addr = {addr[31:2], 2'b00};
      10: begin
        r.wr = 1'b1; r.addr = {addr[31:2], 2'b00};
        case (addr[1:0])
          2'd0: begin r.wstrb = 4'b0001; r.wdata = {24'h0, rt[31:24]}; end
          2'd1: begin r.wstrb = 4'b0011; r.wdata = {16'h0, rt[31:16]}; end
          2'd2: begin r.wstrb = 4'b0111; r.wdata = {8'h0, rt[31:8]}; end
          default: begin r.wstrb = 4'b1111; r.wdata = rt; end
        endcase
      end
      11: begin
        r.wr = 1'b1; r.addr = {addr[31:2], 2'b00};
        case (addr[1:0])
          2'd0: begin r.wstrb = 4'b1111; r.wdata = rt; end
          2'd1: begin r.wstrb = 4'b1110; r.wdata = {rt[23:0], 8'h0}; end
          2'd2: begin r.wstrb = 4'b1100; r.wdata = {rt[15:0], 16'h0}; end
          default: begin r.wstrb = 4'b1000; r.wdata = {rt[7:0], 24'h0}; end
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic req_t bus_now();
    return mk(data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wr_o ? data_wdata_o : 32'h0);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    pipe_stall_i = 1'b0; pipe_flush_i = 1'b0;
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hA5A5A5A5;
    drive_ex(4, 32'h00000003, 32'h0);
    tick();
    tick();
    checks++;
    if ({data_req_o, dmem_stallreq_o, adel_o, ades_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got req/stall/adel/ades=%b required 0000",
               {data_req_o, dmem_stallreq_o, adel_o, ades_o});
    end
    checks++;
    if (mem_memdata_o !== 32'h0) begin
      failures++; $display("FAIL reset_memdata: got %h required 00000000", mem_memdata_o);
    end
    checks++;
    if (mem_memaddr_low_o !== 2'b00 || badvaddr_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: got low=%b badvaddr=%h required 00/00000000", mem_memaddr_low_o, badvaddr_o);
    end
    rst = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    clear_ex();
    tick();
    $display("txn reset done");
  endtask

  task automatic test_sw_fast();
    int stall_cycles;
    stall_cycles = 0;
    drive_ex(7, 32'h10000004, 32'hDEADBEEF);
    data_addr_ok_i = 1'b1;
    req_q.push_back(mk(1'b1, 2'd2, 32'h10000004, 4'b1111, 32'hDEADBEEF));
    settle();
    if (dmem_stallreq_o) stall_cycles++;
    checks++;
    if (data_req_o !== 1'b1) begin
      failures++; $display("FAIL sw_req: got %b required 1", data_req_o);
    end
    got = bus_now(); exp = req_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL sw_bus: got %h required %h", got, exp);
    end
    tick();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
    settle();
    if (dmem_stallreq_o) stall_cycles++;
    checks++;
    if (data_req_o !== 1'b0) begin
      failures++; $display("FAIL sw_req_drop: got %b required 0", data_req_o);
    end
    tick();
    data_data_ok_i = 1'b0;
    clear_ex();
    settle();
    if (dmem_stallreq_o) stall_cycles++;
    checks++;
    if (stall_cycles != 1) begin
      failures++; $display("FAIL sw_stall_cycles: got %0d required 1", stall_cycles);
    end
    $display("txn sw addr=10000004 wdata=deadbeef");
  endtask

  task automatic test_lb_slow();
    drive_ex(0, 32'h20000003, 32'h0);
    req_q.push_back(mk(1'b0, 2'd0, 32'h20000003, 4'b0000, 32'h0));
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        drive_ex(7, 32'hFFFFFFFF, 32'h55555555);
        pipe_stall_i = 1'b1;
      end
      if (c == 3) data_addr_ok_i = 1'b1;
      settle();
      got = bus_now();
      checks++;
      if (data_req_o !== 1'b1 || dmem_stallreq_o !== 1'b1 || got !== req_q[0]) begin
        failures++;
        $display("FAIL lb_hold_c%0d: got req=%b stall=%b bus=%h required req=1 stall=1 bus=%h",
                 c, data_req_o, dmem_stallreq_o, got, req_q[0]);
      end
      if (c == 3) void'(req_q.pop_front());
      tick();
    end
    drive_ex(0, 32'h20000003, 32'h0);
    pipe_stall_i = 1'b0; data_addr_ok_i = 1'b0;
    settle();
    checks++;
    if (dmem_stallreq_o !== 1'b1 || data_req_o !== 1'b0) begin
      failures++; $display("FAIL lb_wait: got stall=%b req=%b required 1/0", dmem_stallreq_o, data_req_o);
    end
    tick();
    data_data_ok_i = 1'b1; data_rdata_i = 32'h80112233;
    rd_q.push_back(32'h80112233);
    settle();
    checks++;
    if (mem_memdata_o !== rd_q[0] || dmem_stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL lb_data: got memdata=%h stall=%b required %h/0", mem_memdata_o, dmem_stallreq_o, rd_q[0]);
    end
    tick();
    data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    clear_ex();
    settle();
    exp_rd = rd_q.pop_front();
    checks++;
    if (mem_memdata_o !== exp_rd || mem_memaddr_low_o !== 2'b11) begin
      failures++;
      $display("FAIL lb_mem: got memdata=%h low=%b required %h/11", mem_memdata_o, mem_memaddr_low_o, exp_rd);
    end
    tick();
    checks++;
    if (mem_memdata_o !== 32'h0) begin
      failures++; $display("FAIL lb_buf_clear: got %h required 00000000", mem_memdata_o);
    end
    $display("txn lb addr=20000003 rdata=80112233");
  endtask

  task automatic test_swl_swr();
    int          ops[2]   = '{10, 11};
    logic [31:0] addrs[2] = '{32'h30000001, 32'h30000002};
    req_t        exps[2];
    exps[0] = mk(1'b1, 2'd2, 32'h30000000, 4'b0011, 32'h0000AABB);
    exps[1] = mk(1'b1, 2'd2, 32'h30000000, 4'b1100, 32'hCCDD0000);
    for (int i = 0; i < 2; i++) begin
      drive_ex(ops[i], addrs[i], 32'hAABBCCDD);
      req_q.push_back(exps[i]);
      data_addr_ok_i = 1'b1;
      settle();
      got = bus_now(); exp = req_q.pop_front();
      checks++;
      if (data_req_o !== 1'b1 || got !== exp) begin
        failures++; $display("FAIL swlr_%0d: got req=%b bus=%h required req=1 bus=%h", i, data_req_o, got, exp);
      end
      tick();
      data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
      tick();
      data_data_ok_i = 1'b0;
      clear_ex();
      $display("txn %s addr=%h wstrb=%b wdata=%h", (i == 0) ? "swl" : "swr", addrs[i], got.wstrb, got.wdata);
    end
    tick();
  endtask

  task automatic test_hold();
    drive_ex(4, 32'h40000000, 32'h0);
    data_addr_ok_i = 1'b1;
    tick();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h12345678;
    pipe_stall_i = 1'b1;
    rd_q.push_back(32'h12345678);
    settle();
    checks++;
    if (mem_memdata_o !== rd_q[0]) begin
      failures++; $display("FAIL hold_data: got %h required %h", mem_memdata_o, rd_q[0]);
    end
    tick();
    data_data_ok_i = 1'b0; data_rdata_i = 32'hFFFF0000;
    settle();
    checks++;
    if (mem_memdata_o !== rd_q[0] || data_req_o !== 1'b0 || dmem_stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_state: got memdata=%h req=%b stall=%b required %h/0/0",
               mem_memdata_o, data_req_o, dmem_stallreq_o, rd_q[0]);
    end
    tick();
    pipe_stall_i = 1'b0;
    settle();
    checks++;
    if (mem_memdata_o !== rd_q[0] || data_req_o !== 1'b0) begin
      failures++; $display("FAIL hold_release: got memdata=%h req=%b required %h/0", mem_memdata_o, data_req_o, rd_q[0]);
    end
    tick();
    clear_ex(); data_rdata_i = 32'h0;
    settle();
    exp_rd = rd_q.pop_front();
    checks++;
    if (mem_memdata_o !== exp_rd || data_req_o !== 1'b0) begin
      failures++; $display("FAIL hold_idle: got memdata=%h req=%b required %h/0", mem_memdata_o, data_req_o, exp_rd);
    end
    tick();
    $display("txn lw hold rdata=12345678");
  endtask

  task automatic test_flush_data();
    drive_ex(4, 32'h50000000, 32'h0);
    data_addr_ok_i = 1'b1;
    tick();
    data_addr_ok_i = 1'b0; pipe_flush_i = 1'b1;
    tick();
    pipe_flush_i = 1'b0;
    drive_ex(4, 32'h50000010, 32'h0);
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (data_req_o !== 1'b0 || dmem_stallreq_o !== 1'b1) begin
        failures++;
        $display("FAIL discard_wait_%0d: got req=%b stall=%b required 0/1", c, data_req_o, dmem_stallreq_o);
      end
      tick();
    end
    data_data_ok_i = 1'b1; data_rdata_i = 32'hBADBAD00;
    settle();
    checks++;
    if (mem_memdata_o !== 32'h0 || data_req_o !== 1'b0) begin
      failures++; $display("FAIL discard_drop: got memdata=%h req=%b required 00000000/0", mem_memdata_o, data_req_o);
    end
    tick();
    data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    clear_ex();
    settle();
    checks++;
    if (mem_memdata_o !== 32'h0 || dmem_stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL discard_exit: got memdata=%h stall=%b required 00000000/0", mem_memdata_o, dmem_stallreq_o);
    end
    tick();
    $display("txn lw flushed in DATA, late data dropped");
  endtask

  task automatic test_flush_addr();
    drive_ex(4, 32'h50000020, 32'h0);
    tick();
    pipe_flush_i = 1'b1;
    tick();
    pipe_flush_i = 1'b0;
    clear_ex();
    settle();
    checks++;
    if (data_req_o !== 1'b0 || dmem_stallreq_o !== 1'b0) begin
      failures++; $display("FAIL flush_addr: got req=%b stall=%b required 0/0", data_req_o, dmem_stallreq_o);
    end
    tick();
    $display("txn lw flushed in ADDR, request withdrawn");
  endtask

  task automatic test_back_to_back();
    int          ops[6]   = '{5, 5, 6, 8, 11, 1};
    logic [31:0] addrs[6] = '{32'h80000001, 32'h80000002, 32'h80000006, 32'h80000103, 32'h80000201, 32'h80000300};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rt, rd;
      rt = $urandom; rd = $urandom;
      drive_ex(ops[i], addrs[i], rt);
      req_q.push_back(model(ops[i], addrs[i], rt));
      data_addr_ok_i = 1'b1;
      settle();
      got = bus_now(); exp = req_q.pop_front();
      checks++;
      if (data_req_o !== 1'b1 || got !== exp) begin
        failures++; $display("FAIL b2b_req_%0d: got req=%b bus=%h required req=1 bus=%h", i, data_req_o, got, exp);
      end
      tick();
      data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = rd;
      rd_q.push_back(rd);
      settle();
      exp_rd = rd_q.pop_front();
      checks++;
      if (mem_memdata_o !== exp_rd) begin
        failures++; $display("FAIL b2b_data_%0d: got %h required %h", i, mem_memdata_o, exp_rd);
      end
      tick();
      data_data_ok_i = 1'b0;
      $display("txn b2b op=%0d addr=%h wstrb=%b", ops[i], addrs[i], got.wstrb);
    end
    clear_ex();
    tick();
  endtask

  task automatic test_addr_err();
    drive_ex(4, 32'h60000002, 32'h0);
    settle();
`ifdef DMEM_EXC_EN
    checks++;
    if (data_req_o !== 1'b0 || dmem_stallreq_o !== 1'b0) begin
      failures++; $display("FAIL adel_noreq: got req=%b stall=%b required 0/0", data_req_o, dmem_stallreq_o);
    end
    tick();
    checks++;
    if (adel_o !== 1'b1 || ades_o !== 1'b0 || badvaddr_o !== 32'h60000002) begin
      failures++;
      $display("FAIL adel: got adel=%b ades=%b bad=%h required 1/0/60000002", adel_o, ades_o, badvaddr_o);
    end
    drive_ex(6, 32'h60000011, 32'h1234);
    settle();
    checks++;
    if (data_req_o !== 1'b0) begin
      failures++; $display("FAIL ades_noreq: got req=%b required 0", data_req_o);
    end
    tick();
    checks++;
    if (adel_o !== 1'b0 || ades_o !== 1'b1 || badvaddr_o !== 32'h60000011) begin
      failures++;
      $display("FAIL ades: got adel=%b ades=%b bad=%h required 0/1/60000011", adel_o, ades_o, badvaddr_o);
    end
    clear_ex();
    tick();
    checks++;
    if (adel_o !== 1'b0 || ades_o !== 1'b0) begin
      failures++; $display("FAIL exc_clear: got adel=%b ades=%b required 0/0", adel_o, ades_o);
    end
    $display("txn misaligned lw/sh raised exceptions");
`else
    req_q.push_back(model(4, 32'h60000002, 32'h0));
    got = bus_now(); exp = req_q.pop_front();
    checks++;
    if (data_req_o !== 1'b1 || got !== exp) begin
      failures++; $display("FAIL misaligned_issue: got req=%b bus=%h required req=1 bus=%h", data_req_o, got, exp);
    end
    data_addr_ok_i = 1'b1;
    tick();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
    tick();
    data_data_ok_i = 1'b0;
    clear_ex();
    settle();
    checks++;
    if (adel_o !== 1'b0 || ades_o !== 1'b0 || badvaddr_o !== 32'h0) begin
      failures++;
      $display("FAIL no_exc: got adel=%b ades=%b bad=%h required 0/0/00000000", adel_o, ades_o, badvaddr_o);
    end
    tick();
    $display("txn misaligned lw issued without exception");
`endif
  endtask

  task automatic test_reset_mid();
    drive_ex(4, 32'h70000000, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_ex();
    settle();
    checks++;
    if (data_req_o !== 1'b0 || dmem_stallreq_o !== 1'b0 || mem_memdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got req=%b stall=%b memdata=%h required 0/0/00000000",
               data_req_o, dmem_stallreq_o, mem_memdata_o);
    end
    tick();
    $display("txn reset during ADDR abandons access");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_ex();
    pipe_stall_i = 1'b0; pipe_flush_i = 1'b0;
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    test_reset();
    test_sw_fast();
    test_lb_slow();
    test_swl_swr();
    test_hold();
    test_flush_data();
    test_flush_addr();
    test_back_to_back();
    test_addr_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
